dma_bus_arbiter: RTL
====================

# dma_bus_arbiter

- Arbitrates the shared data-memory bus between the pipelined CPU's D-cache port and up to `NUM_CH` DMA channels.
- Replaces the fixed `BG = BR` pass-through and tristate muxing:
  - waits for an in-flight CPU cache/memory transaction to drain before granting;
  - picks among competing channels round-robin;
  - drives the memory port through a registered-select multiplexer;
  - stalls the CPU when it touches memory while it does not own the bus.

## Interface
Parameters:
- `NUM_CH`, 2, number of DMA channels (1..8).
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 64, memory data (fetch block) width.
- `MAX_HOLD`, 64, maximum grant length in cycles (used only with the timeout feature).

Ports:
- `clk`  in  1  the single clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_readM`  in  1  CPU cache memory read request.
- `cpu_writeM`  in  1  CPU cache memory write request.
- `cpu_address`  in  ADDR_W  CPU cache memory address.
- `cpu_wdata`  in  DATA_W  CPU cache write data.
- `cpu_busy`  in  1  CPU cache has a memory transaction in flight (miss fill or write-through not finished).
- `cpu_stall`  out  1  CPU must hold; the bus is not owned by the CPU.
- `br`  in  NUM_CH  per-channel bus request.
- `bg`  out  NUM_CH  per-channel bus grant, one-hot or zero.
- `dma_readM`  in  NUM_CH  per-channel read request.
- `dma_writeM`  in  NUM_CH  per-channel write request.
- `dma_address`  in  NUM_CH*ADDR_W  per-channel address, channel i at slice i.
- `dma_wdata`  in  NUM_CH*DATA_W  per-channel write data.
- `mem_readM`  out  1  memory read strobe.
- `mem_writeM`  out  1  memory write strobe.
- `mem_address`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data. Read data is broadcast by memory and does not pass through this block.
- `owner`  out  $clog2(NUM_CH+1)  current owner: 0 = CPU, i+1 = channel i.
- `timeout_err`  out  NUM_CH  one-cycle pulse per forced release (timeout feature only).

## Operation
State machine:
- **IDLE**: the CPU owns the bus and memory ports mirror the `cpu_*` inputs.
  - Any eligible `br` with `!cpu_busy`: go to GRANT.
  - Any eligible `br` with `cpu_busy`: go to DRAIN.
- **DRAIN**: the CPU still drives its in-flight transaction; `cpu_stall`=1 only if the CPU issues a new request. When `cpu_busy`=0, go to GRANT.
- **GRANT**:
  - Winner is latched on entry: the round-robin pick starting at `rr_ptr`.
  - `bg[win]`=1; memory ports mirror channel `win`.
  - `cpu_stall` = `cpu_readM|cpu_writeM`.
  - When `br[win]`=0, go to RELEASE.
- **RELEASE**:
  - One turnaround cycle: all `bg`=0, `mem_readM`=`mem_writeM`=0, `owner`=0, `cpu_stall` as in GRANT.
  - `rr_ptr` = win+1 mod NUM_CH.
  - Go to IDLE.

Rules:
- IDLE always lasts at least one cycle between grants, so the CPU is never starved.
- Requests that drop during DRAIN: if no `br` remains eligible, return to IDLE; no grant is issued.
- A channel's `dma_*` inputs are ignored unless it holds `bg`.
- Reset values: state IDLE, `rr_ptr`=0, `bg`=0, `owner`=0, `cpu_stall`=0, `timeout_err`=0, `mem_readM`=`mem_writeM`=0.
- Reset mid-GRANT: `bg` drops at that edge and no RELEASE cycle is inserted.

## Timing
- `br` rises at edge t with the bus idle: `bg` is high after edge t+1, a one-cycle grant latency.
- `br[win]` falls before edge t: `bg` is low after edge t, RELEASE runs for cycle t..t+1, and IDLE is reached at t+1.
- `bg`, `owner` and the mux select are registered. The memory ports are combinational from the select and the owner's inputs.
- Simultaneous `br` from several channels: the lowest index at or after `rr_ptr` wins.
- `cpu_busy` rising in the same cycle as a `br` rise: DRAIN is taken.

## Configuration
- `DMA_ARB_TIMEOUT_EN` defined:
  - A hold counter of width $clog2(MAX_HOLD+1) clears on GRANT entry and counts each GRANT cycle.
  - On reaching MAX_HOLD: `bg` drops, `timeout_err[win]` pulses for one cycle, and the state goes to RELEASE.
  - The offending channel is then ineligible until it deasserts `br` for at least one cycle.
- Undefined: no counter and no masking; `timeout_err` is tied to 0 and grants are unbounded.

## Structure
- The shared package `dma_arb_pkg` holds:
  - the state encoding (IDLE, DRAIN, GRANT, RELEASE);
  - the owner encoding constant for the CPU (0);
  - the default `MAX_HOLD`.
- One sub-module, `rr_pick`, is combinational. Inputs: request vector and `rr_ptr`. Outputs: winner index and valid.

## Test plan
- **Single channel, idle bus:** `br[0]`=1 at cycle 5 with `cpu_busy`=0 -> `bg`=01 at cycle 6, `owner`=1, `mem_address` = `dma_address[0]`. Drop `br` at cycle 20 -> `bg`=0 at cycle 21 and IDLE at cycle 22.
- **Drain:** `cpu_busy`=1 for cycles 3..7, `br[1]`=1 at cycle 4 -> no grant until `cpu_busy` falls. `bg`=10 one cycle after `cpu_busy`=0 is sampled; the CPU address stays on the bus throughout DRAIN.
- **Round-robin:** with NUM_CH=2, both `br` held continuously -> grants alternate ch0, ch1, ch0. Each grant is separated by RELEASE plus at least one IDLE cycle.
- **CPU stall:** CPU asserts `cpu_readM` during GRANT -> `cpu_stall`=1 and `mem_readM` follows the DMA channel. Stall clears in the first IDLE cycle.
- **Reset mid-grant:** `reset`=1 while `bg`=01 -> all outputs hold reset values after the next edge, and `rr_ptr`=0.
- **Timeout (with `DMA_ARB_TIMEOUT_EN`, MAX_HOLD=8):** `br[0]` stuck high -> `bg[0]` drops after 8 grant cycles and `timeout_err[0]` pulses once. ch0 is not regranted until `br[0]` goes low for one cycle.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// ---------------------------------------------------------------------------
// dma_arb_pkg
//   Shared definitions for the data-memory bus arbiter:
//     - FSM state encoding (IDLE, DRAIN, GRANT, RELEASE)
//     - owner code for the CPU (0; channel i is reported as i+1)
//     - default maximum grant length for the optional hold timeout
//     - ptr_width(): width of a channel index, at least one bit
// ---------------------------------------------------------------------------
package dma_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int OWNER_CPU        = 0;
  localparam int DEFAULT_MAX_HOLD = 64;

  // A single-channel build still needs a one-bit index register.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the lowest-numbered requesting
//   channel at or after i_ptr, wrapping past NUM_CH-1 back to channel 0.
//
//   Ports:
//     i_req   [NUM_CH-1:0]  request vector (already filtered for eligibility)
//     i_ptr   [PTR_W-1:0]   search start index, always < NUM_CH
//     o_win   [PTR_W-1:0]   winning channel index (0 when nothing requests)
//     o_valid               at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [PTR_W-1:0]  o_win,
  output logic              o_valid
);

  // Outer loop walks the search offset in priority order; the first hit
  // along that order wins and later hits are ignored.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!o_valid && i_req[j] && (j == ((int'(i_ptr) + k) % NUM_CH))) begin
          o_valid = 1'b1;
          o_win   = PTR_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter
//   Arbitrates the shared data-memory bus between the CPU D-cache port and
//   NUM_CH DMA channels. The CPU owns the bus by default; a DMA request waits
//   for any in-flight CPU transaction to drain, channels are served
//   round-robin, and a one-cycle RELEASE turnaround plus at least one IDLE
//   cycle separate consecutive grants so the CPU always gets a slot.
//
//   Request/grant handshake: a channel raises br[i] and keeps it high for as
//   long as it wants the bus; bg[i] rises one cycle later at the earliest and
//   stays high until br[i] is seen low (or the hold timeout fires), after
//   which bg[i] is low from the next edge. The channel may only drive its
//   dma_* signals while bg[i] is high; at all other times they are ignored.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     cpu_readM/writeM/address/wdata   CPU cache memory request
//     cpu_busy                   CPU transaction in flight
//     cpu_stall                  CPU must hold (bus owned by DMA)
//     br / bg                    per-channel bus request / grant (one-hot)
//     dma_readM/writeM           per-channel strobes
//     dma_address/dma_wdata      per-channel buses, channel i at slice i
//     mem_readM/writeM/address/wdata   shared memory port
//     owner                      0 = CPU, i+1 = channel i
//     timeout_err                one-cycle pulse per forced release
//     o_dbg_state                FSM state (dma_arb_pkg ST_* encoding)
//     o_dbg_rr_ptr               round-robin search start pointer
//
//   Build option: define DMA_ARB_TIMEOUT_EN to bound each grant to MAX_HOLD
//   cycles. A channel released by timeout is ineligible until it drops br
//   for at least one cycle. Without the macro grants are unbounded and
//   timeout_err is constant 0.
// ---------------------------------------------------------------------------
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_readM,
  input  logic                          cpu_writeM,
  input  logic [ADDR_W-1:0]             cpu_address,
  input  logic [DATA_W-1:0]             cpu_wdata,
  input  logic                          cpu_busy,
  output logic                          cpu_stall,
  input  logic [NUM_CH-1:0]             br,
  output logic [NUM_CH-1:0]             bg,
  input  logic [NUM_CH-1:0]             dma_readM,
  input  logic [NUM_CH-1:0]             dma_writeM,
  input  logic [NUM_CH*ADDR_W-1:0]      dma_address,
  input  logic [NUM_CH*DATA_W-1:0]      dma_wdata,
  output logic                          mem_readM,
  output logic                          mem_writeM,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [$clog2(NUM_CH+1)-1:0]   owner,
  output logic [NUM_CH-1:0]             timeout_err,
  output logic [1:0]                    o_dbg_state,
  output logic [ptr_width(NUM_CH)-1:0]  o_dbg_rr_ptr
);

  localparam int PTR_W = ptr_width(NUM_CH);
  localparam int OWN_W = $clog2(NUM_CH + 1);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  r_win;
  logic [NUM_CH-1:0] r_bg;
  logic [OWN_W-1:0]  r_owner;

  logic [NUM_CH-1:0] w_elig;
  logic [PTR_W-1:0]  w_pick;
  logic              w_pick_valid;
  logic              w_win_req;
  logic              w_cpu_req;
  logic              w_timeout;
  logic              w_grant;
  logic              w_release;
  logic [1:0]        w_next_state;
  logic              w_dma_sel;
  logic [ADDR_W-1:0] w_dma_addr;
  logic [DATA_W-1:0] w_dma_wdata;

  assign w_cpu_req = cpu_readM | cpu_writeM;
  // r_bg is one-hot on the winner during GRANT, so this is br[win].
  assign w_win_req = |(br & r_bg);

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_terr;

  assign w_elig = br & ~r_mask;
  // Fires on the last allowed GRANT cycle; a voluntary release in the same
  // cycle takes precedence and is not reported as a timeout.
  assign w_timeout = (r_state == ST_GRANT) && w_win_req && (r_hold == HOLD_LAST);
  assign timeout_err = r_terr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      r_mask <= '0;
      r_terr <= '0;
    end else begin
      // The hold count sits at zero outside GRANT, so it starts fresh on entry.
      if (r_state == ST_GRANT) r_hold <= r_hold + 1'b1;
      else                     r_hold <= '0;
      // A mask bit survives only while the channel keeps br high.
      r_mask <= (r_mask & br) | (w_timeout ? r_bg : '0);
      r_terr <= w_timeout ? r_bg : '0;
    end
  end
`else
  assign w_elig      = br;
  assign w_timeout   = 1'b0;
  assign timeout_err = '0;
`endif

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_win   (w_pick),
    .o_valid (w_pick_valid)
  );

  // Next-state decode. w_grant latches the pick; w_release ends the grant.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          if (cpu_busy) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_GRANT;
            w_grant      = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // All requests withdrawn while draining: give up without a grant.
        if (!w_pick_valid) begin
          w_next_state = ST_IDLE;
        end else if (!cpu_busy) begin
          w_next_state = ST_GRANT;
          w_grant      = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!w_win_req || w_timeout) begin
          w_next_state = ST_RELEASE;
          w_release    = 1'b1;
        end
      end
      ST_RELEASE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_bg     <= '0;
      r_owner  <= OWN_W'(OWNER_CPU);
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_win   <= w_pick;
        r_bg    <= NUM_CH'(1) << w_pick;
        r_owner <= OWN_W'(w_pick) + OWN_W'(1);
      end else if (w_release) begin
        r_bg     <= '0;
        r_owner  <= OWN_W'(OWNER_CPU);
        r_rr_ptr <= (r_win == LAST_CH) ? '0 : r_win + 1'b1;
      end
    end
  end

  // CPU stall: in DRAIN the in-flight transaction (cpu_busy high) proceeds;
  // a fresh request is held only once a grant is actually pending.
  always_comb begin
    cpu_stall = 1'b0;
    case (r_state)
      ST_IDLE:    cpu_stall = 1'b0;
      ST_DRAIN:   cpu_stall = w_cpu_req && !cpu_busy && w_pick_valid;
      ST_GRANT,
      ST_RELEASE: cpu_stall = w_cpu_req;
      default:    cpu_stall = 1'b0;
    endcase
  end

  // Registered one-hot r_bg is the mux select; only the granted slice passes.
  always_comb begin
    w_dma_addr  = '0;
    w_dma_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_bg[i]) begin
        w_dma_addr  = dma_address[i*ADDR_W +: ADDR_W];
        w_dma_wdata = dma_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_dma_sel = |r_bg;

  // With no channel selected the CPU drives the port, except in the RELEASE
  // turnaround or while the CPU is stalled, when the strobes stay low.
  assign mem_readM   = w_dma_sel ? |(dma_readM & r_bg)
                                 : (cpu_readM && !cpu_stall && (r_state != ST_RELEASE));
  assign mem_writeM  = w_dma_sel ? |(dma_writeM & r_bg)
                                 : (cpu_writeM && !cpu_stall && (r_state != ST_RELEASE));
  assign mem_address = w_dma_sel ? w_dma_addr  : cpu_address;
  assign mem_wdata   = w_dma_sel ? w_dma_wdata : cpu_wdata;

  assign bg           = r_bg;
  assign owner        = r_owner;
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule
